// File: rtl/alu_sequencer.sv
// Sequencer for an external 8-bit ALU: accepts one command and iterates it
// cmd_rep+1 times over the A/D registers, then holds the result until consumed.
module alu_sequencer #(
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [5:0]       cmd_ctrl,
  input  logic [1:0]       cmd_dst,
  input  logic             cmd_ysel,
  input  logic [7:0]       cmd_imm,
  input  logic [REP_W-1:0] cmd_rep,
  output logic             alu_zx,
  output logic             alu_nx,
  output logic             alu_zy,
  output logic             alu_ny,
  output logic             alu_f,
  output logic             alu_no,
  output logic [7:0]       alu_x,
  output logic [7:0]       alu_y,
  input  logic [7:0]       alu_o,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_data,
  output logic             res_zr,
  output logic             res_ng,
  output logic [7:0]       a_q,
  output logic [7:0]       d_q,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state_q, state_d;
  logic [5:0]         ctrl_q, ctrl_d;
  logic [1:0]         dst_q, dst_d;
  logic               ysel_q, ysel_d;
  logic [7:0]         imm_q, imm_d;
  logic [REP_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         a_d, d_d;
  logic [7:0]         res_q, res_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ctrl_q  <= '0;
      dst_q   <= '0;
      ysel_q  <= 1'b0;
      imm_q   <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      d_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      dst_q   <= dst_d;
      ysel_q  <= ysel_d;
      imm_q   <= imm_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      d_q     <= d_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    dst_d   = dst_q;
    ysel_d  = ysel_q;
    imm_d   = imm_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    d_d     = d_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          ctrl_d  = cmd_ctrl;
          dst_d   = cmd_dst;
          ysel_d  = cmd_ysel;
          imm_d   = cmd_imm;
          cnt_d   = cmd_rep;
          state_d = EXEC;
        end
      end
      EXEC: begin
        // Each iteration commits the ALU result so the next one sees updated A/D.
        if (dst_q[0]) a_d = alu_o;
        if (dst_q[1]) d_d = alu_o;
        res_d = alu_o;
        if (cnt_q != '0) cnt_d = cnt_q - REP_W'(1);
        else             state_d = RESP;
      end
      RESP: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = ctrl_q;
  assign alu_x     = d_q;
  assign alu_y     = ysel_q ? imm_q : a_q;
  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign res_valid = (state_q == RESP);
  assign res_data  = res_q;
  assign res_zr    = (res_q == 8'h00);
  assign res_ng    = res_q[7];

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomised and directed bench for alu_sequencer, with a Hack-style ALU as
// the environment and a per-command arithmetic model of A, D and the result.
module tb_alu_sequencer;
  localparam int REP_W = 4;

  logic             clk;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [5:0]       cmd_ctrl;
  logic [1:0]       cmd_dst;
  logic             cmd_ysel;
  logic [7:0]       cmd_imm;
  logic [REP_W-1:0] cmd_rep;
  logic             alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
  logic [7:0]       alu_x, alu_y, alu_o;
  logic             res_valid;
  logic             res_ready;
  logic [7:0]       res_data;
  logic             res_zr, res_ng;
  logic [7:0]       a_q, d_q;
  logic             busy;

  alu_sequencer #(.REP_W(REP_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ctrl(cmd_ctrl), .cmd_dst(cmd_dst), .cmd_ysel(cmd_ysel),
    .cmd_imm(cmd_imm), .cmd_rep(cmd_rep),
    .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy), .alu_ny(alu_ny),
    .alu_f(alu_f), .alu_no(alu_no),
    .alu_x(alu_x), .alu_y(alu_y), .alu_o(alu_o),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_zr(res_zr), .res_ng(res_ng),
    .a_q(a_q), .d_q(d_q), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] hack(input logic [7:0] x, input logic [7:0] y,
                                      input logic [5:0] c);
    logic [7:0] xx, yy, o;
    xx = c[5] ? 8'h00 : x;
    if (c[4]) xx = ~xx;
    yy = c[3] ? 8'h00 : y;
    if (c[2]) yy = ~yy;
    o = c[1] ? (xx + yy) : (xx & yy);
    if (c[0]) o = ~o;
    return o;
  endfunction

  assign alu_o = hack(alu_x, alu_y, {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no});

  int total = 0;
  int bad   = 0;
  logic [7:0] ma = 8'h00;
  logic [7:0] md = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic randomize_cmd_fields();
    cmd_ctrl = 6'($urandom);
    cmd_dst  = 2'($urandom);
    cmd_ysel = 1'($urandom);
    cmd_imm  = 8'($urandom);
    cmd_rep  = REP_W'($urandom);
  endtask

  // Issue one command, check every EXEC cycle and the RESP window against the model.
  task automatic send_cmd(input logic [5:0] c, input logic [1:0] dst, input logic ys,
                          input logic [7:0] imm, input int rep, input int hold,
                          input bit valid_in_resp, input bit expect_now);
    logic [7:0] xs [16];
    logic [7:0] yv [16];
    logic [7:0] r, y;
    int waits;
    r = 8'h00;
    for (int i = 0; i <= rep; i++) begin
      y = ys ? imm : ma;
      xs[i] = md;
      yv[i] = y;
      r = hack(md, y, c);
      if (dst[0]) ma = r;
      if (dst[1]) md = r;
    end

    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_ctrl  = c;
    cmd_dst   = dst;
    cmd_ysel  = ys;
    cmd_imm   = imm;
    cmd_rep   = REP_W'(rep);
    waits = 0;
    while (!cmd_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 50) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: cmd_ready never rose within %0d cycles", waits);
    end
    if (expect_now) check("accept_first_idle_waits", waits, 0);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    randomize_cmd_fields();

    for (int i = 0; i <= rep; i++) begin
      @(negedge clk);
      check("exec_busy", busy, 1);
      check("exec_res_valid", res_valid, 0);
      check("exec_cmd_ready", cmd_ready, 0);
      check("exec_alu_x", alu_x, xs[i]);
      check("exec_alu_y", alu_y, yv[i]);
      check("exec_ctrl", {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}, c);
    end

    @(negedge clk);
    check("resp_valid", res_valid, 1);
    check("resp_data", res_data, r);
    check("resp_zr", res_zr, (r == 8'h00));
    check("resp_ng", res_ng, r[7]);
    check("resp_a", a_q, ma);
    check("resp_d", d_q, md);
    check("resp_cmd_ready", cmd_ready, 0);
    for (int h = 0; h < hold; h++) begin
      if (valid_in_resp) begin
        cmd_valid = 1'b1;
        randomize_cmd_fields();
      end
      @(negedge clk);
      check("hold_valid", res_valid, 1);
      check("hold_data", res_data, r);
      check("hold_cmd_ready", cmd_ready, 0);
      check("hold_ctrl", {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}, c);
      check("hold_a", a_q, ma);
      check("hold_d", d_q, md);
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    $display("txn ctrl=%b dst=%b ysel=%0d imm=%0h rep=%0d -> res=%0h A=%0h D=%0h waits=%0d",
             c, dst, ys, imm, rep, r, ma, md, waits);
  endtask

  // Output relations that must hold every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      check("inv_alu_x", alu_x, d_q);
      check("inv_zr", res_zr, (res_data == 8'h00));
      check("inv_ng", res_ng, res_data[7]);
      check("inv_ready", cmd_ready, !busy);
      if (res_valid) check("inv_valid_busy", busy, 1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    cmd_ctrl  = '0;
    cmd_dst   = '0;
    cmd_ysel  = 1'b0;
    cmd_imm   = '0;
    cmd_rep   = '0;
    #1;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_a", a_q, 0);
    check("rst_d", d_q, 0);
    check("rst_res_data", res_data, 0);
    check("rst_ctrl", {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // A=5, D=0, then D+=A three times
    send_cmd(6'b110000, 2'b01, 1'b1, 8'd5, 0, 0, 1'b0, 1'b1);
    check("lit_a5", a_q, 8'd5);
    send_cmd(6'b101010, 2'b10, 1'b0, 8'd0, 0, 0, 1'b0, 1'b1);
    send_cmd(6'b000010, 2'b10, 1'b0, 8'd0, 2, 0, 1'b0, 1'b1);
    check("lit_d15", d_q, 8'd15);
    check("lit_res15", res_data, 8'd15);

    // D=250 then D+1 sixteen times wraps to 10
    send_cmd(6'b110000, 2'b10, 1'b1, 8'd250, 0, 0, 1'b0, 1'b1);
    check("lit_d250", d_q, 8'd250);
    send_cmd(6'b011111, 2'b10, 1'b0, 8'd0, 15, 0, 1'b0, 1'b1);
    check("lit_d10", d_q, 8'd10);
    check("lit_wrap_zr", res_zr, 0);
    check("lit_wrap_ng", res_ng, 0);

    // A=D=3, constant -1 to nowhere, held 5 cycles with a command waiting
    send_cmd(6'b110000, 2'b11, 1'b1, 8'd3, 0, 0, 1'b0, 1'b1);
    send_cmd(6'b111010, 2'b00, 1'b0, 8'd0, 0, 5, 1'b1, 1'b1);
    check("lit_neg1", res_data, 8'hFF);
    check("lit_neg1_ng", res_ng, 1);
    check("lit_a3", a_q, 8'd3);
    check("lit_d3", d_q, 8'd3);

    // Constant 0 into both, must be taken on the first IDLE cycle
    send_cmd(6'b101010, 2'b11, 1'b0, 8'd0, 0, 0, 1'b0, 1'b1);
    check("lit_zero_a", a_q, 8'd0);
    check("lit_zero_d", d_q, 8'd0);
    check("lit_zero_zr", res_zr, 1);

    // Reset during the 2nd EXEC cycle of a rep=7 command
    send_cmd(6'b110000, 2'b11, 1'b1, 8'd9, 0, 0, 1'b0, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_ctrl  = 6'b000010;
    cmd_dst   = 2'b11;
    cmd_ysel  = 1'b1;
    cmd_imm   = 8'd7;
    cmd_rep   = REP_W'(7);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_cmd_ready", cmd_ready, 1);
    check("abort_a", a_q, 0);
    check("abort_d", d_q, 0);
    check("abort_res_data", res_data, 0);
    check("abort_res_valid", res_valid, 0);
    check("abort_ctrl", {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}, 0);
    ma = 8'h00;
    md = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("post_abort_res_valid", res_valid, 0);
      check("post_abort_busy", busy, 0);
    end
    $display("txn reset abort during EXEC -> A=%0h D=%0h", a_q, d_q);

    // Randomised commands
    for (int n = 0; n < 40; n++) begin
      send_cmd(6'($urandom), 2'($urandom), 1'($urandom), 8'($urandom),
               int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
               1'($urandom), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The module SHALL have one parameter: REP_W, default 4, width of the repeat-count field.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  reset; the block SHALL use one clock with asynchronous, active-low reset.
REQ-004 cmd_valid  input  1  command offered.
REQ-005 cmd_ready  output  1  command accepted when high together with cmd_valid.
REQ-006 cmd_ctrl  input  6  ALU control bits: [5]=zx, [4]=nx, [3]=zy, [2]=ny, [1]=f, [0]=no.
REQ-007 cmd_dst  input  2  result destination: 00 none, 01 A, 10 D, 11 A and D.
REQ-008 cmd_ysel  input  1  ALU Y source: 0 = register A, 1 = cmd_imm.
REQ-009 cmd_imm  input  8  immediate operand.
REQ-010 cmd_rep  input  REP_W  extra iterations; the command executes cmd_rep+1 times.
REQ-011 alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no  output  1 each  drive the external 8-bit ALU.
REQ-012 alu_x  output  8  ALU X operand; it SHALL always equal register D.
REQ-013 alu_y  output  8  ALU Y operand; A or the latched immediate, per ysel.
REQ-014 alu_o  input  8  combinational ALU result.
REQ-015 res_valid  output  1  result available.
REQ-016 res_ready  input  1  result consumed.
REQ-017 res_data, res_zr, res_ng  output  8/1/1  final result, zero flag, negative flag.
REQ-018 a_q, d_q  output  8 each  current A and D register values.
REQ-019 busy  output  1  high whenever the state is not IDLE.

Function
REQ-020 The FSM SHALL have exactly three states: IDLE, EXEC and RESP.
REQ-021 cmd_ready SHALL be high only in IDLE.
REQ-022 On handshake the block SHALL latch ctrl, dst, ysel, imm and rep, load iteration counter = cmd_rep, and move IDLE->EXEC.
REQ-023 ALU control outputs SHALL come from the latched ctrl and SHALL hold their last value outside EXEC.
REQ-024 In each EXEC cycle the block SHALL write alu_o into the registers selected by dst at the clock edge.
REQ-025 In each EXEC cycle the block SHALL also capture alu_o into res_data.
REQ-026 Each following iteration SHALL use the updated A and D values.
REQ-027 When the counter is nonzero in EXEC, it SHALL decrement and the FSM SHALL stay in EXEC.
REQ-028 When the counter is zero in EXEC, the FSM SHALL go to RESP.
REQ-029 Latency SHALL be cmd_rep+1 EXEC cycles; res_valid SHALL rise on the cycle after the last EXEC cycle.
REQ-030 res_valid SHALL be high only in RESP, and res_data and the flags SHALL hold stable until res_ready.
REQ-031 The block SHALL go RESP->IDLE on res_ready.
REQ-032 A cmd_valid arriving during RESP SHALL NOT be accepted before the next IDLE cycle.
REQ-033 res_zr SHALL equal (res_data==0), and res_ng SHALL equal res_data[7].
REQ-034 All arithmetic SHALL be modulo 256 with no overflow flag, and A/D updates SHALL wrap silently.
REQ-035 With dst=00, A and D SHALL remain unchanged while the result is still reported.
REQ-036 With dst=11, A and D SHALL both receive the same value in the same cycle.
REQ-037 cmd_* inputs SHALL be ignored outside the handshake cycle, so changes during EXEC have no effect.

Reset
REQ-038 While rst_n is low, the block SHALL asynchronously force: state IDLE, A=0, D=0, counter=0, latched fields=0, res_data=0.
REQ-039 Under the same reset, all ALU control outputs SHALL be 0, and res_valid=0, busy=0, cmd_ready=1.
REQ-040 Reset asserted mid-EXEC or mid-RESP SHALL abort the operation with no partial result reported afterwards.
REQ-041 After rst_n deasserts, the first command SHALL be accepted on the first clock edge with cmd_valid high.

Verification
REQ-042 The bench SHALL load A=5 (ctrl 110000, ysel 1, imm 5, dst 01), then D=0 (ctrl 101010, dst 10), then D+A (ctrl 000010, dst 10, rep 2) -> D=15, res_data=15, 3 EXEC cycles.
REQ-043 The bench SHALL run D=250, then D+1 (ctrl 011111, dst 10, rep 15) -> 16 EXEC cycles, D=10 (wrap), res_zr=0, res_ng=0.
REQ-044 The bench SHALL run constant -1 (ctrl 111010, dst 00) with A=D=3 -> res_data=0xFF, res_ng=1, A and D still 3.
REQ-045 The bench SHALL hold res_ready low for 5 cycles in RESP while cmd_valid=1 -> res_valid and res_data stable, cmd_ready=0, and the command is accepted on the first IDLE cycle.
REQ-046 The bench SHALL pulse rst_n low during the 2nd EXEC cycle of a rep=7 command -> immediate IDLE with A=D=0, and no res_valid pulse afterwards.
REQ-047 The bench SHALL run constant 0 (ctrl 101010, dst 11) -> A=D=0, res_zr=1, latency exactly 1 EXEC cycle.
